boot_loader_mem: RTL
====================

# boot_loader_mem

Word-addressed program/data memory that answers the multicycle RISC-V core's memory bus (`adr`, `writedata`, `memwrite`, `readdata`) and fills itself from the UART before the core runs. In the load phase it consumes received bytes, assembles little-endian words, writes them from word 0 upward, sends one acknowledge byte, then releases the core's reset. It sits between `uart_unit`'s byte handshake and the core top.

## Interface
- `ADDR_WIDTH`, default 14: word-address bits; depth = 2^ADDR_WIDTH words.
- `clk` in 1: the one clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `tx_data` out 8: byte to send; constant `ACK_BYTE`.
- `tx_go` out 1: one-cycle send request.
- `tx_done` in 1: one-cycle strobe, transmit finished.
- `core_rstn` out 1: active-low reset to the core; low until the run phase.
- `adr` in 32: core byte address.
- `writedata` in 32: core store data.
- `memwrite` in 1: core store strobe.
- `readdata` out 32: registered read data.

## Operation
- Reset values: state `S_LEN`, byte counter 0, word index 0, `core_rstn`=0, `tx_go`=0, `readdata`=0. Memory contents are not cleared.
- Load stream: 4 bytes of word count N (LSB first), then 4N bytes of words, each LSB first.
- `S_LEN`: shift in 4 bytes; on the 4th, latch N. If N=0, go to `S_ACK`; otherwise go to `S_DATA`.
- `S_DATA`: assemble bytes. On each 4th byte, write the word at word index w and increment w. After word N-1, go to `S_ACK`.
- Overflow: words with w ≥ 2^ADDR_WIDTH are discarded. Their bytes are still consumed. The index does not wrap, so word 0 is never overwritten.
- `S_ACK`: assert `tx_go` for exactly the first cycle in the state. Wait for `tx_done`, then go to `S_RUN`. `rx_valid` is ignored.
- `S_RUN`: terminal until `rst`. `rx_valid` is ignored.
- `core_rstn` is 1 only in `S_RUN`.
- Core bus, `S_RUN` only:
  - Word address = `adr[ADDR_WIDTH+1:2]`. `adr[1:0]` is ignored.
  - In range means `adr[31:ADDR_WIDTH+2]`==0.
  - In-range store: the word is written at the clock edge where `memwrite`=1.
  - Out-of-range store: dropped.
  - Out-of-range read: `readdata`=0.
  - Outside `S_RUN`, `memwrite` is ignored.
- Read during write to the same word returns the old data (read-first).
- Reset mid-load: immediate return to `S_LEN` with counters cleared. Partially written words stay in memory and the host must resend the whole stream.

## Timing
- `readdata` is valid in the cycle after `adr` is presented (one-cycle synchronous read). In-range reads are registered, in every state.
- Load write happens at the clock edge of the 4th byte's `rx_valid`, in the same cycle.
- Entry to `S_ACK` is the cycle after the last byte. `tx_go` is high in that first `S_ACK` cycle only.
- `core_rstn` rises on the clock edge after `tx_done` is sampled.
- `rx_valid` and `tx_done` are single-cycle pulses. Back-to-back `rx_valid` on consecutive cycles is supported.

## Structure
- Package `boot_pkg`: state enum `boot_state_t` {`S_LEN`, `S_DATA`, `S_ACK`, `S_RUN`} and `ACK_BYTE` = 8'hAA.
- Sub-module `word_ram`: single-port, read-first, registered-output RAM, 2^ADDR_WIDTH × 32. The loader and the core share its port through a mux selected by state; the two phases are mutually exclusive.
- Top: FSM, 2-bit byte counter, 32-bit shift register, word index of ADDR_WIDTH+1 bits, N register of 32 bits.

## Test plan
- Normal load:
  - Stimulus: bytes 02 00 00 00, 13 00 00 00, EF BE AD DE; `tx_done` 10 cycles after `tx_go`.
  - Response: single `tx_go` with `tx_data`=AA, then `core_rstn`=1. In run, `adr`=4 gives `readdata`=DEADBEEF next cycle; `adr`=0 gives 00000013.
- Empty load:
  - Stimulus: 00 00 00 00.
  - Response: `tx_go` the cycle after the 4th byte; `core_rstn`=1 after `tx_done`; no memory write.
- Reset mid-load:
  - Stimulus: `rst` pulse after 5 bytes of a 1-word load, then a full 01 00 00 00, 78 56 34 12 stream.
  - Response: word 0 reads 12345678; exactly one `tx_go`.
- Core store and range check:
  - Stimulus: store 0xCAFEF00D at `adr`=8, then read `adr`=8; then store at `adr`=0x80000000, then read `adr`=0x80000000.
  - Response: first read returns CAFEF00D; out-of-range read returns 0; the out-of-range store changes no word.
- Overflow with `ADDR_WIDTH`=2:
  - Stimulus: load N=5 with words 1..5.
  - Response: words 0..3 read 1..4; word 0 not overwritten by 5; ack still sent.
- Ignored inputs:
  - Stimulus: `memwrite`=1 during load; `rx_valid` pulses in `S_ACK` and `S_RUN`.
  - Response: memory and state unchanged.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader memory.
package boot_pkg;

    typedef enum logic [1:0] {
        S_LEN,
        S_DATA,
        S_ACK,
        S_RUN
    } boot_state_t;

    localparam logic [7:0] ACK_BYTE = 8'hAA;

endpackage

// File: rtl/word_ram.sv
// Single-port 32-bit word RAM with a registered, read-first output.
// A deasserted read enable zeros the output register instead of loading it.
module word_ram #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [2**ADDR_WIDTH];
    logic [31:0] r_rdata;

    // Storage has no reset so it survives a host reload request.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end else begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/boot_loader_mem.sv
// Boot memory: fills itself from a length-prefixed UART byte stream, acknowledges it,
// then releases the core and serves its word-addressed memory bus.
module boot_loader_mem
    import boot_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_go,
    input  logic        i_tx_done,
    output logic        o_core_rstn,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_writedata,
    input  logic        i_memwrite,
    output logic [31:0] o_readdata
);

    localparam logic [ADDR_WIDTH:0] IDX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    boot_state_t           r_state;
    boot_state_t           w_nextState;
    logic [1:0]            r_byteCnt;
    logic [31:0]           r_shift;
    logic [ADDR_WIDTH:0]   r_wordIdx;
    logic [31:0]           r_wordsLeft;
    logic                  r_txGo;
    logic                  r_coreRstn;

    logic [31:0]           w_word;
    logic                  w_lastByte;
    logic                  w_consume;
    logic                  w_inRange;
    logic                  w_ramWe;
    logic [ADDR_WIDTH-1:0] w_ramAddr;
    logic [31:0]           w_ramWdata;

    assign w_word     = {i_rx_data, r_shift[31:8]};
    assign w_lastByte = i_rx_valid && (r_byteCnt == 2'd3);
    assign w_consume  = i_rx_valid && ((r_state == S_LEN) || (r_state == S_DATA));
    assign w_inRange  = (i_adr >> (ADDR_WIDTH + 2)) == 32'd0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_LEN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The RAM port belongs to the loader until the run phase, then to the core.
    always_comb begin
        w_nextState = r_state;
        w_ramWe     = 1'b0;
        w_ramAddr   = r_wordIdx[ADDR_WIDTH-1:0];
        w_ramWdata  = w_word;
        case (r_state)
            S_LEN: begin
                if (w_lastByte) begin
                    w_nextState = (w_word == 32'd0) ? S_ACK : S_DATA;
                end
            end
            S_DATA: begin
                w_ramWe = w_lastByte && !r_wordIdx[ADDR_WIDTH];
                if (w_lastByte && (r_wordsLeft == 32'd1)) begin
                    w_nextState = S_ACK;
                end
            end
            S_ACK: begin
                if (i_tx_done) begin
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                w_ramAddr  = i_adr[ADDR_WIDTH+1:2];
                w_ramWe    = i_memwrite && w_inRange;
                w_ramWdata = i_writedata;
            end
            default: w_nextState = S_LEN;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_byteCnt   <= '0;
            r_shift     <= '0;
            r_wordIdx   <= '0;
            r_wordsLeft <= '0;
            r_txGo      <= 1'b0;
            r_coreRstn  <= 1'b0;
        end else begin
            r_txGo     <= (w_nextState == S_ACK) && (r_state != S_ACK);
            r_coreRstn <= (w_nextState == S_RUN);
            if (w_consume) begin
                r_shift   <= w_word;
                r_byteCnt <= r_byteCnt + 2'd1;
                if (r_byteCnt == 2'd3) begin
                    if (r_state == S_LEN) begin
                        r_wordsLeft <= w_word;
                    end else begin
                        r_wordsLeft <= r_wordsLeft - 32'd1;
                        // Saturate at the first out-of-range slot so word 0 is never reused.
                        if (!r_wordIdx[ADDR_WIDTH]) begin
                            r_wordIdx <= r_wordIdx + IDX_ONE;
                        end
                    end
                end
            end
        end
    end

    word_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_we   (w_ramWe),
        .i_re   (w_inRange),
        .i_addr (w_ramAddr),
        .i_wdata(w_ramWdata),
        .o_rdata(o_readdata)
    );

    assign o_tx_data   = ACK_BYTE;
    assign o_tx_go     = r_txGo;
    assign o_core_rstn = r_coreRstn;

endmodule
